// File: rtl/note_pkg.sv
// Shared note codes, types and sample mapping for the mic pitch path.
// Also used by the game controller for its finish sentinel.
package note_pkg;

  localparam int NOTE_BITS = 7;

  typedef logic [NOTE_BITS-1:0] note_t;

  localparam note_t SILENCE_NOTE  = 7'd0;
  localparam note_t NOTE_SENTINEL = 7'h7F;

  typedef enum logic [1:0] {
    SILENT,
    ACQUIRE,
    LOCKED
  } stab_state_t;

  // Quiet samples and the finish sentinel both read as silence.
  function automatic note_t map_sample(
    input note_t n,
    input logic  loud,
    input note_t silence
  );
    return (loud && n != NOTE_SENTINEL) ? n : silence;
  endfunction

endpackage

// File: rtl/note_stabilizer_if.sv
// Raw pitch stream in, debounced note out.
// The master drives the raw side; the stabilizer is the slave.
interface note_stabilizer_if;
  import note_pkg::*;

  note_t raw_note;
  logic  raw_valid;
  logic  raw_loud;
  note_t stable_note;
  logic  note_changed;
  logic  locked;

  modport master (
    output raw_note,
    output raw_valid,
    output raw_loud,
    input  stable_note,
    input  note_changed,
    input  locked
  );

  modport slave (
    input  raw_note,
    input  raw_valid,
    input  raw_loud,
    output stable_note,
    output note_changed,
    output locked
  );

endinterface

// File: rtl/timeout_counter.sv
// Saturating idle counter: clear restarts it, expire_pulse marks
// the single cycle whose edge takes the count to TERM.
module timeout_counter #(
  parameter int unsigned          WIDTH = 24,
  parameter logic [WIDTH-1:0]     TERM  = '1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_expired,
  output logic o_expire_pulse
);

  localparam logic [WIDTH-1:0] PRE = TERM - WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != TERM) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_expired      = (r_cnt == TERM);
  assign o_expire_pulse = !i_clear && (r_cnt == PRE);

endmodule

// File: rtl/note_stabilizer.sv
// Debounces the raw detector note into the controller's mic_note,
// with an idle timeout that forces silence.
module note_stabilizer
  import note_pkg::*;
#(
  parameter int unsigned NOTE_BITS    = note_pkg::NOTE_BITS,
  parameter int unsigned STABLE_COUNT = 4,
  parameter logic [23:0] HOLD_CYCLES  = 24'd5_000_000,
  parameter note_t       SILENCE_NOTE = note_pkg::SILENCE_NOTE
) (
  input  logic               clk_in,
  input  logic               rst_in,
  note_stabilizer_if.slave   bus
);

  localparam logic [3:0] SC = 4'(STABLE_COUNT);

  stab_state_t r_state;
  stab_state_t w_state_n;

  logic [NOTE_BITS-1:0] r_cand;
  logic [NOTE_BITS-1:0] r_stable;
  logic [3:0]           r_cnt;
  logic                 r_chg;

  logic [NOTE_BITS-1:0] w_s;
  logic [NOTE_BITS-1:0] w_cand_n;
  logic [NOTE_BITS-1:0] w_stable_n;
  logic [3:0]           w_cnt_n;
  logic [3:0]           w_cnt_inc;
  logic                 w_match;
  logic                 w_sat;
  logic                 w_restart;
  logic                 w_expired;
  logic                 w_expire_pulse;
  logic                 w_timeout;
  logic                 w_locked;

  timeout_counter #(
    .WIDTH (24),
    .TERM  (HOLD_CYCLES - 24'd1)
  ) u_idle (
    .i_clk          (clk_in),
    .i_rst          (rst_in),
    .i_clear        (bus.raw_valid),
    .o_expired      (w_expired),
    .o_expire_pulse (w_expire_pulse)
  );

  // A valid strobe clears the timer, so it always beats the timeout.
  assign w_timeout = w_expire_pulse && !w_expired;

  assign w_s       = map_sample(bus.raw_note, bus.raw_loud, SILENCE_NOTE);
  assign w_match   = (w_s == r_cand);
  assign w_cnt_inc = (r_cnt >= SC) ? SC : r_cnt + 4'd1;

  always_comb begin
    w_cand_n = r_cand;
    w_cnt_n  = r_cnt;
    if (w_timeout) begin
      w_cand_n = SILENCE_NOTE;
      w_cnt_n  = 4'd0;
    end else if (bus.raw_valid) begin
      if (w_match) begin
        w_cnt_n = w_cnt_inc;
      end else begin
        w_cand_n = w_s;
        w_cnt_n  = 4'd1;
      end
    end
  end

  assign w_sat     = bus.raw_valid && (w_cnt_n == SC);
  assign w_restart = bus.raw_valid && !w_match;

  always_comb begin
    w_stable_n = r_stable;
    if (w_timeout) begin
      w_stable_n = SILENCE_NOTE;
    end else if (w_sat) begin
      w_stable_n = w_cand_n;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cand   <= SILENCE_NOTE;
      r_cnt    <= 4'd0;
      r_stable <= SILENCE_NOTE;
      r_chg    <= 1'b0;
    end else begin
      r_cand   <= w_cand_n;
      r_cnt    <= w_cnt_n;
      r_stable <= w_stable_n;
      r_chg    <= (w_stable_n != r_stable);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= SILENT;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (1'b1)
      w_timeout: w_state_n = SILENT;
      w_sat: begin
        w_state_n = (w_cand_n == SILENCE_NOTE) ? SILENT : LOCKED;
      end
      w_restart: w_state_n = ACQUIRE;
      default: ;
    endcase
  end

  always_comb begin
    w_locked = (r_state == LOCKED);
  end

  assign bus.stable_note  = r_stable;
  assign bus.note_changed = r_chg;
  assign bus.locked       = w_locked;

endmodule

// File: tb/tb_note_stabilizer.sv
// Directed plus random bench for note_stabilizer against a
// run-length reference model.
module tb_note_stabilizer;
  import note_pkg::*;

  localparam int SC   = 4;
  localparam int HOLD = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  note_stabilizer_if bus ();

  note_stabilizer #(
    .STABLE_COUNT (SC),
    .HOLD_CYCLES  (24'd100)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  // Model: length of the current run of identical samples and idle time.
  int   run  = 0;
  int   idle = 0;
  logic [6:0] m_cand   = 7'd0;
  logic [6:0] m_stable = 7'd0;
  logic       m_chg    = 1'b0;
  logic       m_lock   = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [6:0] n, input bit loud);
    logic [6:0] prev;
    logic [6:0] s;
    bus.raw_valid = v;
    bus.raw_note  = n;
    bus.raw_loud  = loud;
    @(posedge clk);
    prev = m_stable;
    if (rst) begin
      run = 0; idle = 0; m_cand = 0; m_stable = 0;
    end else if (v) begin
      idle = 0;
      s = (loud && n != 7'h7F) ? n : 7'd0;
      if (s == m_cand) run++;
      else begin
        m_cand = s;
        run = 1;
      end
      if (run == SC && m_cand != m_stable) m_stable = m_cand;
    end else begin
      idle++;
      if (idle == HOLD - 1) begin
        m_cand = 0; run = 0; m_stable = 0;
      end
    end
    m_chg  = !rst && (m_stable != prev);
    m_lock = (run >= SC) && (m_cand == m_stable) && (m_stable != 0);
    #1;
    chk("stable_note", int'(bus.stable_note), int'(m_stable));
    chk("note_changed", int'(bus.note_changed), int'(m_chg));
    chk("locked", int'(bus.locked), int'(m_lock));
    if (bus.note_changed) pulses++;
    bus.raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 7'd0, 0);
    rst = 1'b0;
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++) cyc(0, 7'd0, 0);
  endtask

  task automatic strobe(input logic [6:0] n, input bit loud, input int gap);
    cyc(1, n, loud);
    idle_n(gap);
  endtask

  initial begin
    bus.raw_valid = 1'b0;
    bus.raw_note  = 7'd0;
    bus.raw_loud  = 1'b0;

    do_reset();
    chk("reset_stable", int'(bus.stable_note), 0);
    chk("reset_locked", int'(bus.locked), 0);

    // Acceptance after the 4th strobe, one pulse
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 7'd60, 1);
      if (k == 3) chk("acc_3rd", int'(bus.stable_note), 0);
      if (k == 4) begin
        chk("acc_4th", int'(bus.stable_note), 60);
        chk("acc_pulse", int'(bus.note_changed), 1);
      end
      idle_n(3);
    end
    chk("acc_pulses", pulses, 1);
    chk("acc_locked", int'(bus.locked), 1);

    // Glitch rejection, then move to 62
    pulses = 0;
    strobe(7'd62, 1, 2);
    for (int k = 0; k < 3; k++) strobe(7'd60, 1, 2);
    chk("glitch_hold", int'(bus.stable_note), 60);
    chk("glitch_pulses", pulses, 0);
    for (int k = 0; k < 4; k++) strobe(7'd62, 1, 1);
    chk("move_62", int'(bus.stable_note), 62);
    chk("move_pulses", pulses, 1);

    // Sentinel maps to silence
    for (int k = 0; k < 4; k++) strobe(7'd60, 1, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) strobe(7'h7F, 1, 1);
    chk("sentinel_stable", int'(bus.stable_note), 0);
    chk("sentinel_pulses", pulses, 1);

    // Quiet samples map to silence
    for (int k = 0; k < 4; k++) strobe(7'd60, 1, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) strobe(7'd64, 0, 1);
    chk("quiet_stable", int'(bus.stable_note), 0);
    chk("quiet_pulses", pulses, 1);

    // Timeout on idle cycle 99
    for (int k = 0; k < 4; k++) strobe(7'd60, 1, 0);
    pulses = 0;
    idle_n(98);
    chk("to_before", int'(bus.stable_note), 60);
    idle_n(1);
    chk("to_fire", int'(bus.stable_note), 0);
    chk("to_pulse", int'(bus.note_changed), 1);
    idle_n(300);
    chk("to_once", pulses, 1);

    // Strobe on cycle 99 suppresses the timeout
    for (int k = 0; k < 4; k++) strobe(7'd60, 1, 0);
    pulses = 0;
    idle_n(98);
    cyc(1, 7'd60, 1);
    idle_n(5);
    chk("supp_stable", int'(bus.stable_note), 60);
    chk("supp_pulses", pulses, 0);

    // Reset mid-acquisition discards the candidate
    do_reset();
    for (int k = 0; k < 3; k++) strobe(7'd60, 1, 1);
    do_reset();
    chk("mid_rst_stable", int'(bus.stable_note), 0);
    chk("mid_rst_chg", int'(bus.note_changed), 0);
    chk("mid_rst_locked", int'(bus.locked), 0);
    for (int k = 0; k < 3; k++) strobe(7'd60, 1, 1);
    chk("mid_rst_restart", int'(bus.stable_note), 0);
    strobe(7'd60, 1, 1);
    chk("mid_rst_accept", int'(bus.stable_note), 60);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] n;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: n = 7'd60;
        1: n = 7'd62;
        2: n = 7'd64;
        3: n = 7'h7F;
        4: n = 7'd0;
        default: n = 7'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else if ($urandom_range(0, 149) == 0) idle_n(int'($urandom_range(90, 110)));
      else cyc($urandom_range(0, 2) == 0, n, $urandom_range(0, 7) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
